// File: rtl/data_memory_responder_if.sv
// MEM-stage to data-memory link: request side and response side.
interface data_memory_responder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  MemRead;
  logic                  MemWrite;
  logic [31:0]           ALUResult;
  logic [DATA_WIDTH-1:0] read_data2;
  logic [DATA_WIDTH-1:0] ReadData;
  logic                  ack;
  logic                  err;
  logic                  stall;

  modport master (
    output req, MemRead, MemWrite,
    output ALUResult, read_data2,
    input  ReadData, ack, err, stall
  );

  modport slave (
    input  req, MemRead, MemWrite,
    input  ALUResult, read_data2,
    output ReadData, ack, err, stall
  );
endinterface

// File: rtl/data_memory_responder.sv
// Word-addressed data RAM with wait states and req/ack handshake.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned read/write answers with err.
module data_memory_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 2
) (
  input logic                    clk,
  input logic                    rst,
  data_memory_responder_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] WS = WAIT_STATES[3:0];

  logic [1:0]            state;
  logic [3:0]            waitCnt;
  logic [ADDR_WIDTH-1:0] idxQ;
  logic [DATA_WIDTH-1:0] dataQ;
  logic [DATA_WIDTH-1:0] rdData;
  logic                  rdQ;
  logic                  wrQ;
  logic                  errQ;
  logic                  misTrap;
  logic                  badOp;
  logic                  doRd;
  logic                  doWr;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misQ;
  assign misTrap = misQ & (rdQ | wrQ);
`else
  assign misTrap = 1'b0;
`endif

  // Conflicting qualifiers or a trapped misalignment suppress the access.
  assign badOp = (rdQ & wrQ) | misTrap;
  assign doRd  = rdQ & ~badOp;
  assign doWr  = wrQ & ~badOp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      waitCnt <= '0;
      idxQ    <= '0;
      dataQ   <= '0;
      rdData  <= '0;
      rdQ     <= 1'b0;
      wrQ     <= 1'b0;
      errQ    <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      misQ    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req) begin
            idxQ    <= bus.ALUResult[ADDR_WIDTH+1:2];
            dataQ   <= bus.read_data2;
            rdQ     <= bus.MemRead;
            wrQ     <= bus.MemWrite;
`ifdef DMEM_MISALIGN_TRAP_EN
            misQ    <= |bus.ALUResult[1:0];
`endif
            waitCnt <= WS;
            state   <= (WS != 4'd0) ? WAIT : ACCESS;
          end
        end
        WAIT: begin
          waitCnt <= waitCnt - 4'd1;
          if (waitCnt <= 4'd1) state <= ACCESS;
        end
        ACCESS: begin
          errQ <= badOp;
          if (badOp)     rdData <= '0;
          else if (doRd) rdData <= mem[idxQ];
          state <= RESP;
        end
        RESP: state <= IDLE;
      endcase
    end
  end

  // Reset forces IDLE, so a write cut short by rst never lands.
  always_ff @(posedge clk) begin
    if (state == ACCESS && doWr) mem[idxQ] <= dataQ;
  end

  logic unusedAddr;
  assign unusedAddr = ^{bus.ALUResult[31:ADDR_WIDTH+2],
                        bus.ALUResult[1:0]};

  assign bus.ack      = (state == RESP);
  assign bus.err      = bus.ack & errQ;
  assign bus.stall    = bus.req & ~bus.ack;
  assign bus.ReadData = rdData;

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder with a word-array model.
// Expectations follow DMEM_MISALIGN_TRAP_EN when it is defined.
module tb_data_memory_responder;

  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;
  localparam int WS    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_memory_responder_if #(.DATA_WIDTH(32)) bus ();

  data_memory_responder #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (32),
    .WAIT_STATES(WS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit          err;
    bit          chk;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon;
  int passed = 0;
  int total  = 0;

  logic [31:0] model [DEPTH];
  bit          known [DEPTH];
  logic [31:0] lastRd;
  bit          lastKnown;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference behaviour: word array indexed by byte address / 4 mod depth.
  task automatic pushExp(input bit rd, input bit wr,
                         input logic [31:0] addr, input logic [31:0] data,
                         input string nm);
    int idx;
    bit mis;
    bit bad;
    exp_t e;
    idx = int'(addr / 4) % DEPTH;
`ifdef DMEM_MISALIGN_TRAP_EN
    mis = (addr % 4) != 0;
`else
    mis = 1'b0;
`endif
    bad = (rd && wr) || (mis && (rd || wr));
    e.name = nm;
    if (bad) begin
      lastRd = 0;
      lastKnown = 1;
      e.err = 1; e.chk = 1; e.data = 0;
    end else if (rd) begin
      e.err = 0;
      lastKnown = known[idx];
      lastRd = model[idx];
      e.chk = known[idx]; e.data = model[idx];
    end else begin
      if (wr) begin
        model[idx] = data;
        known[idx] = 1;
      end
      e.err = 0; e.chk = lastKnown; e.data = lastRd;
    end
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.ack === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", {31'd0, bus.ack}, 32'd0);
      end else begin
        mon = sb.pop_front();
        check({mon.name, "_err"}, {31'd0, bus.err}, {31'd0, mon.err});
        if (mon.chk) check({mon.name, "_data"}, bus.ReadData, mon.data);
      end
    end
  end

  task automatic doOp(input bit rd, input bit wr,
                      input logic [31:0] addr, input logic [31:0] data,
                      input string nm);
    int stalls;
    bit got;
    stalls = 0;
    got = 0;
    @(posedge clk); #1;
    pushExp(rd, wr, addr, data, nm);
    bus.req = 1; bus.MemRead = rd; bus.MemWrite = wr;
    bus.ALUResult = addr; bus.read_data2 = data;
    repeat (50) begin
      @(negedge clk);
      if (bus.ack === 1'b1) begin
        got = 1;
        break;
      end
      if (bus.stall === 1'b1) stalls++;
    end
    if (!got) begin
      total++;
      $display("FAIL %s_timeout: got no ack expected ack", nm);
      if (sb.size() > 0) void'(sb.pop_back());
    end else begin
      check({nm, "_stalls"}, stalls, WS + 2);
    end
    @(posedge clk); #1;
    bus.req = 0; bus.MemRead = 0; bus.MemWrite = 0;
    bus.ALUResult = $urandom; bus.read_data2 = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int r;
    lastRd = 0; lastKnown = 1;
    for (int i = 0; i < DEPTH; i++) known[i] = 0;
    rst = 1;
    bus.req = 0; bus.MemRead = 0; bus.MemWrite = 0;
    bus.ALUResult = 0; bus.read_data2 = 0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_ack", {31'd0, bus.ack}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    check("rst_rdata", bus.ReadData, 32'd0);
    check("rst_stall", {31'd0, bus.stall}, 32'd0);
    @(negedge clk); rst = 0;

    doOp(0, 1, 32'd0, 32'd100, "wr0");
    doOp(1, 0, 32'd0, 32'd0, "rd0");
    doOp(0, 1, 32'd4, 32'd1111, "wr4");
    doOp(1, 0, 32'd4, 32'd0, "rd4");
    doOp(1, 0, 32'd0, 32'd0, "rd0b");
    doOp(1, 0, 32'(4 * DEPTH), 32'd0, "rdwrap");
    doOp(1, 1, 32'd0, 32'd0, "both");
    doOp(1, 0, 32'd0, 32'd0, "rd0c");
    doOp(0, 0, 32'd0, 32'd0, "noop");

    doOp(0, 1, 32'd8, 32'd77, "wr8");
    doOp(1, 0, 32'd8, 32'd0, "rd8");
    @(posedge clk); #1;
    bus.req = 1; bus.MemRead = 0; bus.MemWrite = 1;
    bus.ALUResult = 32'd8; bus.read_data2 = 32'd55;
    @(posedge clk); @(posedge clk); #1;
    rst = 1;
    #1;
    check("midrst_ack", {31'd0, bus.ack}, 32'd0);
    check("midrst_err", {31'd0, bus.err}, 32'd0);
    check("midrst_rdata", bus.ReadData, 32'd0);
    bus.req = 0; bus.MemWrite = 0;
    lastRd = 0; lastKnown = 1;
    @(negedge clk); rst = 0;
    repeat (8) @(posedge clk);
    doOp(1, 0, 32'd8, 32'd0, "rd8_after_rst");

    doOp(0, 1, 32'd2, 32'd7, "wr_mis");
    doOp(1, 0, 32'd0, 32'd0, "rd0_after_mis");

    for (int i = 0; i < 60; i++) begin
      a = 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 5) == 0) a = a + 32'(DEPTH * 4 * $urandom_range(1, 7));
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      r = $urandom_range(0, 9);
      if (r == 0)      doOp(1, 1, a, $urandom, "rnd_both");
      else if (r == 1) doOp(0, 0, a, $urandom, "rnd_noop");
      else if (r < 6)  doOp(0, 1, a, $urandom, "rnd_wr");
      else             doOp(1, 0, a, $urandom, "rnd_rd");
    end

    repeat (5) @(posedge clk);
    check("sb_drain", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
